// File: rtl/sram_ctrl.sv
// sram_ctrl: single-beat initiator for a 512K x 8 asynchronous SRAM (CY62148E class).
// Turns one read or write request at a time into a timed strobe sequence on the SRAM pins.
// Every strobe, the address and the bus drive enable come straight from flops, so nothing
// glitches at the pins.
//
// Ports
//   clk, rst_n         clock (rising edge) and synchronous active-low reset
//   req_valid/ready    request handshake; transfer when both are high at a rising edge
//   req_we             1 = write, 0 = read
//   req_addr/wdata     word address and write data, latched on accept
//   rsp_valid          one-cycle pulse when rsp_rdata holds fresh read data
//   rsp_rdata          last read data, held until the next read completes
//   busy               high whenever the controller is not idle
//   sram_ce_b/we_b/oe_b  active-low SRAM strobes
//   sram_addr          SRAM address, stable for a whole access
//   sram_data          shared data bus, driven only while writing (WRITE and WHOLD)

module sram_ctrl #(
   parameter int unsigned READ_CYCLES  = 5,  // clocks oe_b/ce_b low per read (>= 2)
   parameter int unsigned WRITE_CYCLES = 5,  // clocks we_b low per write (>= 1)
   parameter int unsigned TURN_CYCLES  = 1   // idle clocks after every access (>= 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [18:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        busy,
   output logic        sram_ce_b,
   output logic        sram_we_b,
   output logic        sram_oe_b,
   output logic [18:0] sram_addr,
   inout  wire  [7:0]  sram_data
);

   localparam int unsigned MaxRw     = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
   localparam int unsigned MaxCycles = (MaxRw > TURN_CYCLES) ? MaxRw : TURN_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t ReadInit  = cnt_t'(READ_CYCLES - 1);
   localparam cnt_t WriteInit = cnt_t'(WRITE_CYCLES - 1);
   localparam cnt_t TurnInit  = cnt_t'(TURN_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWrite,
      StWhold,
      StTurn
   } state_e;

   state_e      state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic [18:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        ce_b_q, ce_b_d;
   logic        we_b_q, we_b_d;
   logic        oe_b_q, oe_b_d;
   logic        drive_q, drive_d;

   // Next state, counter and captured data.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (req_we) begin
                  state_d = StWrite;
                  cnt_d   = WriteInit;
               end else begin
                  state_d = StRead;
                  cnt_d   = ReadInit;
               end
            end
         end
         StRead: begin
            if (cnt_q == '0) begin
               // oe_b is still low up to this edge, so the bus holds valid SRAM data.
               rdata_d     = sram_data;
               rsp_valid_d = 1'b1;
               state_d     = StTurn;
               cnt_d       = TurnInit;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         StWrite: begin
            if (cnt_q == '0) begin
               state_d = StWhold;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         StWhold: begin
            state_d = StTurn;
            cnt_d   = TurnInit;
         end
         StTurn: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Pin values are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      ce_b_d  = 1'b1;
      we_b_d  = 1'b1;
      oe_b_d  = 1'b1;
      drive_d = 1'b0;
      ready_d = (state_d == StIdle);
      busy_d  = (state_d != StIdle);
      case (state_d)
         StRead: begin
            ce_b_d = 1'b0;
            oe_b_d = 1'b0;
         end
         StWrite: begin
            ce_b_d  = 1'b0;
            we_b_d  = 1'b0;
            drive_d = 1'b1;
         end
         StWhold: begin
            // we_b has risen; keep chip selected and data driven to meet data hold time.
            ce_b_d  = 1'b0;
            drive_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         ce_b_q      <= 1'b1;
         we_b_q      <= 1'b1;
         oe_b_q      <= 1'b1;
         drive_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         ce_b_q      <= ce_b_d;
         we_b_q      <= we_b_d;
         oe_b_q      <= oe_b_d;
         drive_q     <= drive_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign busy      = busy_q;
   assign sram_ce_b = ce_b_q;
   assign sram_we_b = we_b_q;
   assign sram_oe_b = oe_b_q;
   assign sram_addr = addr_q;
   assign sram_data = drive_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: instance a uses default timing, instance b uses 2/1/3 read/write/turn.
// Each instance talks to its own behavioural SRAM. Requests push expected accesses and
// read responses into queues; negedge monitors pop and compare them and check bus rules.

module tb_sram_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n     [2];
   logic        req_valid [2];
   logic        req_we    [2];
   logic [18:0] req_addr  [2];
   logic [7:0]  req_wdata [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [7:0]  rsp_rdata [2];
   logic        busy      [2];
   logic        ce_b      [2];
   logic        we_b      [2];
   logic        oe_b      [2];
   logic [18:0] sram_addr [2];

   wire  [7:0]  sd_a;
   wire  [7:0]  sd_b;
   logic [7:0]  mem_a [0:524287];
   logic [7:0]  mem_b [0:524287];

   // Behavioural SRAMs: drive on read, capture on every clock with we_b and ce_b low.
   assign sd_a = (!ce_b[0] && !oe_b[0] && we_b[0]) ? mem_a[sram_addr[0]] : 8'hzz;
   assign sd_b = (!ce_b[1] && !oe_b[1] && we_b[1]) ? mem_b[sram_addr[1]] : 8'hzz;
   always @(posedge clk) if (!ce_b[0] && !we_b[0]) mem_a[sram_addr[0]] <= sd_a;
   always @(posedge clk) if (!ce_b[1] && !we_b[1]) mem_b[sram_addr[1]] <= sd_b;

   sram_ctrl u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n[0]),
      .req_valid (req_valid[0]),
      .req_ready (req_ready[0]),
      .req_we    (req_we[0]),
      .req_addr  (req_addr[0]),
      .req_wdata (req_wdata[0]),
      .rsp_valid (rsp_valid[0]),
      .rsp_rdata (rsp_rdata[0]),
      .busy      (busy[0]),
      .sram_ce_b (ce_b[0]),
      .sram_we_b (we_b[0]),
      .sram_oe_b (oe_b[0]),
      .sram_addr (sram_addr[0]),
      .sram_data (sd_a)
   );

   sram_ctrl #(
      .READ_CYCLES  (2),
      .WRITE_CYCLES (1),
      .TURN_CYCLES  (3)
   ) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n[1]),
      .req_valid (req_valid[1]),
      .req_ready (req_ready[1]),
      .req_we    (req_we[1]),
      .req_addr  (req_addr[1]),
      .req_wdata (req_wdata[1]),
      .rsp_valid (rsp_valid[1]),
      .rsp_rdata (rsp_rdata[1]),
      .busy      (busy[1]),
      .sram_ce_b (ce_b[1]),
      .sram_we_b (we_b[1]),
      .sram_oe_b (oe_b[1]),
      .sram_addr (sram_addr[1]),
      .sram_data (sd_b)
   );

   function automatic int rcyc(input int i);
      return (i == 0) ? 5 : 2;
   endfunction
   function automatic int wcyc(input int i);
      return (i == 0) ? 5 : 1;
   endfunction
   function automatic int tcyc(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   typedef struct { int inst; logic [7:0] data; int due; } rsp_t;
   typedef struct { int inst; bit we; logic [18:0] addr; } acc_t;
   rsp_t rsp_q[$];
   acc_t acc_q[$];

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      nchk++;
      if (!ok) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor state per instance.
   bit          mon_en      = 1'b0;
   bit          prev_ce [2] = '{1'b1, 1'b1};
   bit          gap_ok  [2] = '{1'b0, 1'b0};
   int          run_we  [2] = '{0, 0};
   int          run_oe  [2] = '{0, 0};
   int          turn    [2] = '{0, 0};
   int          gap     [2] = '{0, 0};
   logic [18:0] acc_addr [2];

   always @(negedge clk) begin
      rsp_t e;
      acc_t a;
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i]) begin
               chk(rsp_q.size() > 0, "rsp_expected", rsp_q.size(), 1);
               if (rsp_q.size() > 0) begin
                  e = rsp_q.pop_front();
                  chk(e.inst == i, "rsp_inst", i, e.inst);
                  chk(rsp_rdata[i] == e.data, "rsp_data", int'(rsp_rdata[i]), int'(e.data));
                  chk(cyc == e.due, "rsp_latency", cyc, e.due);
               end
            end
            if (!rst_n[i]) begin
               run_we[i]  = 0;
               run_oe[i]  = 0;
               turn[i]    = 0;
               gap_ok[i]  = 1'b0;
               prev_ce[i] = 1'b1;
            end else begin
               chk(!(!oe_b[i] && !we_b[i]), "oe_we_both_low", 0, 1);
               chk(req_ready[i] == !busy[i], "ready_vs_busy", int'(req_ready[i]), int'(!busy[i]));
               if (!ce_b[i] && prev_ce[i]) begin
                  chk(acc_q.size() > 0, "acc_expected", acc_q.size(), 1);
                  if (acc_q.size() > 0) begin
                     a = acc_q.pop_front();
                     chk(a.inst == i, "acc_inst", i, a.inst);
                     chk(sram_addr[i] == a.addr, "acc_addr", int'(sram_addr[i]), int'(a.addr));
                     chk(a.we ? !we_b[i] : !oe_b[i], "acc_type", int'(a.we), int'(we_b[i]));
                  end
                  if (gap_ok[i]) chk(gap[i] >= tcyc(i) + 1, "idle_gap", gap[i], tcyc(i) + 1);
                  acc_addr[i] = sram_addr[i];
               end else if (!ce_b[i]) begin
                  chk(sram_addr[i] == acc_addr[i], "addr_stable", int'(sram_addr[i]),
                      int'(acc_addr[i]));
               end
               if (ce_b[i]) begin
                  if (!prev_ce[i]) begin
                     gap[i]    = 0;
                     gap_ok[i] = 1'b1;
                  end
                  gap[i]++;
               end
               if (!we_b[i]) run_we[i]++;
               else if (run_we[i] > 0) begin
                  chk(run_we[i] == wcyc(i), "we_width", run_we[i], wcyc(i));
                  run_we[i] = 0;
               end
               if (!oe_b[i]) run_oe[i]++;
               else if (run_oe[i] > 0) begin
                  chk(run_oe[i] == rcyc(i), "oe_width", run_oe[i], rcyc(i));
                  run_oe[i] = 0;
               end
               if (busy[i] && ce_b[i]) turn[i]++;
               else if (!busy[i] && turn[i] > 0) begin
                  chk(turn[i] == tcyc(i), "turn_cycles", turn[i], tcyc(i));
                  turn[i] = 0;
               end
               prev_ce[i] = ce_b[i];
            end
         end
      end
   end

   // Present a request and hold it until accepted; leaves req_valid high for back-to-back use.
   // For reads, data is the expected read data and req_wdata gets its complement.
   task automatic issue(input int i, input bit we, input logic [18:0] addr, input logic [7:0] data,
                        input bit exp_rsp);
      bit   rdy;
      int   n = 0;
      rsp_t r;
      acc_t a;
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i]  = addr;
      req_wdata[i] = we ? data : ~data;
      do begin
         rdy = req_ready[i];
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 200);
      chk(rdy, "accept_timeout", n, 200);
      a.inst = i;
      a.we   = we;
      a.addr = addr;
      acc_q.push_back(a);
      if (!we && exp_rsp) begin
         r.inst = i;
         r.data = data;
         r.due  = cyc + rcyc(i);
         rsp_q.push_back(r);
      end
   endtask

   task automatic idle(input int i);
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n = 0;
      while ((busy[i] || rsp_q.size() != 0) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(n < 200, "wait_idle_timeout", n, 200);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_n[i]     = 1'b0;
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
      end

      // Reset held for three clocks.
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk(ce_b[i] == 1'b1, "rst_ce_b", int'(ce_b[i]), 1);
         chk(we_b[i] == 1'b1, "rst_we_b", int'(we_b[i]), 1);
         chk(oe_b[i] == 1'b1, "rst_oe_b", int'(oe_b[i]), 1);
         chk(rsp_valid[i] == 1'b0, "rst_rsp_valid", int'(rsp_valid[i]), 0);
         chk(rsp_rdata[i] == 8'h00, "rst_rsp_rdata", int'(rsp_rdata[i]), 0);
         chk(busy[i] == 1'b0, "rst_busy", int'(busy[i]), 0);
         chk(sram_addr[i] == 19'h0, "rst_sram_addr", int'(sram_addr[i]), 0);
         rst_n[i] = 1'b1;
      end
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      chk(req_ready[0] == 1'b1, "ready_after_reset", int'(req_ready[0]), 1);

      // Single write then read back; a write must not disturb rsp_rdata.
      issue(0, 1'b1, 19'h12345, 8'h5A, 1'b0);
      idle(0);
      wait_idle(0);
      chk(rsp_rdata[0] == 8'h00, "rdata_kept_over_write", int'(rsp_rdata[0]), 0);
      issue(0, 1'b0, 19'h12345, 8'h5A, 1'b1);
      idle(0);
      wait_idle(0);

      // Back-to-back with req_valid held, address extremes.
      issue(0, 1'b1, 19'h7FFFF, 8'hFF, 1'b0);
      issue(0, 1'b1, 19'h00000, 8'h01, 1'b0);
      issue(0, 1'b0, 19'h7FFFF, 8'hFF, 1'b1);
      issue(0, 1'b0, 19'h00000, 8'h01, 1'b1);
      idle(0);
      wait_idle(0);
      chk(rsp_rdata[0] == 8'h01, "rdata_after_b2b", int'(rsp_rdata[0]), 1);

      // Reset during the third READ clock: no response, strobes high on the next clock.
      issue(0, 1'b0, 19'h12345, 8'h5A, 1'b0);
      idle(0);
      repeat (2) @(posedge clk);
      #1;
      rst_n[0] = 1'b0;
      @(posedge clk);
      #1;
      chk(ce_b[0] == 1'b1, "midrst_ce_b", int'(ce_b[0]), 1);
      chk(oe_b[0] == 1'b1, "midrst_oe_b", int'(oe_b[0]), 1);
      chk(we_b[0] == 1'b1, "midrst_we_b", int'(we_b[0]), 1);
      chk(busy[0] == 1'b0, "midrst_busy", int'(busy[0]), 0);
      @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      @(posedge clk);
      #1;
      issue(0, 1'b0, 19'h12345, 8'h5A, 1'b1);
      idle(0);
      wait_idle(0);

      // Short-timing instance: write/read back-to-back.
      issue(1, 1'b1, 19'h00010, 8'hA5, 1'b0);
      issue(1, 1'b0, 19'h00010, 8'hA5, 1'b1);
      idle(1);
      wait_idle(1);
      chk(rsp_rdata[1] == 8'hA5, "b_rdata_final", int'(rsp_rdata[1]), 8'hA5);

      chk(rsp_q.size() == 0, "rsp_queue_drained", rsp_q.size(), 0);
      chk(acc_q.size() == 0, "acc_queue_drained", acc_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
